// File: rtl/multi_sine_pwm.sv
`default_nettype none
// ============================================================================
// multi_sine_pwm : multi-channel DDS sine-weighted PWM generator
// Revision      : 1.0
// ============================================================================
module multi_sine_pwm #(
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned PHASE_BITS = 24,
  parameter logic        IDLE_LEVEL = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [PHASE_BITS-1:0] freq_word,
  input  logic [8*CHANNELS-1:0] phase_offset,
  input  logic [7:0]            amplitude,
  output logic [CHANNELS-1:0]   pwm,
  output logic                  period_tick,
  output logic                  busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_SCALE  = 2'd2;
  localparam logic [1:0] ST_STORE  = 2'd3;

  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;
  localparam logic [2:0]          LAST_CH = 3'(CHANNELS - 1);

  // Quarter-wave table: SINE_QTR[j] = floor(128 + 127.5*sin(2*pi*j/256)), j = 0..64
  localparam logic [7:0] SINE_QTR [0:64] = '{
    8'd128, 8'd131, 8'd134, 8'd137, 8'd140, 8'd143, 8'd146, 8'd149,
    8'd152, 8'd155, 8'd158, 8'd162, 8'd165, 8'd167, 8'd170, 8'd173,
    8'd176, 8'd179, 8'd182, 8'd185, 8'd188, 8'd190, 8'd193, 8'd196,
    8'd198, 8'd201, 8'd203, 8'd206, 8'd208, 8'd211, 8'd213, 8'd215,
    8'd218, 8'd220, 8'd222, 8'd224, 8'd226, 8'd228, 8'd230, 8'd232,
    8'd234, 8'd235, 8'd237, 8'd238, 8'd240, 8'd241, 8'd243, 8'd244,
    8'd245, 8'd246, 8'd248, 8'd249, 8'd250, 8'd250, 8'd251, 8'd252,
    8'd253, 8'd253, 8'd254, 8'd254, 8'd254, 8'd255, 8'd255, 8'd255,
    8'd255
  };

  generate
    if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
      $error("multi_sine_pwm: CHANNELS must be 1..8");
    end
    if (PWM_BITS < 8 || PWM_BITS > 16) begin : g_bad_pwm_bits
      $error("multi_sine_pwm: PWM_BITS must be 8..16");
    end
    if (PHASE_BITS < 8) begin : g_bad_phase_bits
      $error("multi_sine_pwm: PHASE_BITS must be >= 8");
    end
    if ((2 ** PWM_BITS) < (4 * CHANNELS + 4)) begin : g_bad_period
      $error("multi_sine_pwm: PWM period too short for the duty sequencer");
    end
  endgenerate

  // Lower half of the wave is the mirrored upper half; 255-v is exact there
  // because 127.5*sin never lands on an integer except at index 0/128.
  function automatic logic [7:0] sine_lut(input logic [7:0] k);
    logic [6:0] j;
    logic [6:0] m;
    logic [7:0] v;
    j = k[6:0];
    m = (j <= 7'd64) ? j : (~j + 7'd1);
    v = SINE_QTR[m];
    return (k[7] && (j != 7'd0)) ? (8'd255 - v) : v;
  endfunction

  logic [PWM_BITS-1:0]                cnt_q, cnt_d;
  logic [PHASE_BITS-1:0]              phase_acc_q, phase_acc_d;
  logic [PHASE_BITS-1:0]              freq_q, freq_d;
  logic [7:0]                         amp_q, amp_d;
  logic [8*CHANNELS-1:0]              offset_q, offset_d;
  logic [1:0]                         state_q, state_d;
  logic [2:0]                         ch_q, ch_d;
  logic [7:0]                         lut_q, lut_d;
  logic [7:0]                         sample_q, sample_d;
  logic [CHANNELS-1:0][PWM_BITS-1:0]  shadow_q, shadow_d;
  logic [CHANNELS-1:0][PWM_BITS-1:0]  active_q, active_d;
  logic [CHANNELS-1:0]                pwm_q, pwm_d;

  logic [7:0]          offset_sel;
  logic [7:0]          lut_index;
  logic signed [8:0]   lut_diff;
  logic signed [17:0]  scaled_prod;
  logic [7:0]          scaled_sample;
  logic [PWM_BITS-1:0] duty;

  always_comb begin
    offset_sel = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_q == 3'(c)) begin
        offset_sel = offset_q[8*c +: 8];
      end
    end
    lut_index     = phase_acc_q[PHASE_BITS-1 -: 8] + offset_sel;
    lut_diff      = $signed({1'b0, lut_q}) - 9'sd128;
    scaled_prod   = lut_diff * $signed({1'b0, amp_q});
    // Arithmetic shift floors toward -inf; the +128 result always fits 0..254.
    scaled_sample = 8'(scaled_prod >>> 8) + 8'd128;
    duty          = PWM_BITS'(sample_q) << (PWM_BITS - 8);
  end

  always_comb begin
    cnt_d       = cnt_q + 1'b1;
    phase_acc_d = phase_acc_q;
    freq_d      = freq_q;
    amp_d       = amp_q;
    offset_d    = offset_q;
    state_d     = state_q;
    ch_d        = ch_q;
    lut_d       = lut_q;
    sample_d    = sample_q;
    shadow_d    = shadow_q;
    active_d    = active_q;

    if (cnt_q == '0) begin
      freq_d   = freq_word;
      amp_d    = amplitude;
      offset_d = phase_offset;
    end

    if (cnt_q == CNT_MAX) begin
      phase_acc_d = phase_acc_q + freq_q;
      active_d    = shadow_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (cnt_q == '0) begin
          state_d = ST_LOOKUP;
          ch_d    = 3'd0;
        end
      end
      ST_LOOKUP: begin
        lut_d   = sine_lut(lut_index);
        state_d = ST_SCALE;
      end
      ST_SCALE: begin
        sample_d = scaled_sample;
        state_d  = ST_STORE;
      end
      ST_STORE: begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (ch_q == 3'(c)) begin
            shadow_d[c] = duty;
          end
        end
        if (ch_q == LAST_CH) begin
          state_d = ST_IDLE;
        end else begin
          ch_d    = ch_q + 3'd1;
          state_d = ST_LOOKUP;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    for (int c = 0; c < CHANNELS; c++) begin
      pwm_d[c] = en ? (cnt_q < active_q[c]) : IDLE_LEVEL;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      phase_acc_q <= '0;
      freq_q      <= '0;
      amp_q       <= '0;
      offset_q    <= '0;
      state_q     <= ST_IDLE;
      ch_q        <= 3'd0;
      lut_q       <= '0;
      sample_q    <= '0;
      shadow_q    <= '0;
      active_q    <= '0;
      pwm_q       <= {CHANNELS{IDLE_LEVEL}};
    end else begin
      cnt_q       <= cnt_d;
      phase_acc_q <= phase_acc_d;
      freq_q      <= freq_d;
      amp_q       <= amp_d;
      offset_q    <= offset_d;
      state_q     <= state_d;
      ch_q        <= ch_d;
      lut_q       <= lut_d;
      sample_q    <= sample_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      pwm_q       <= pwm_d;
    end
  end

  // Gated by rst_n so the counter's reset value of 0 does not raise a tick.
  assign period_tick = rst_n && (cnt_q == '0);
  assign busy        = (state_q != ST_IDLE);
  assign pwm         = pwm_q;

endmodule
`default_nettype wire

// File: doc/multi_sine_pwm.md
MULTI_SINE_PWM -- requirements
Module: multi_sine_pwm

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of independent PWM outputs (1..8).
REQ-002 SHALL have parameter PWM_BITS, default 8, PWM counter width; period = 2^PWM_BITS clk cycles (8..16).
REQ-003 SHALL have parameter PHASE_BITS, default 24, DDS phase accumulator width (>= 8).
REQ-004 SHALL have parameter IDLE_LEVEL, default 1'b1, level driven on pwm outputs while disabled.
REQ-005 SHALL use one clock and a synchronous, active-low reset.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst_n  input  1  synchronous, active-low reset.
REQ-008 en  input  1  active-high output enable.
REQ-009 freq_word  input  PHASE_BITS  phase increment added once per PWM period.
REQ-010 phase_offset  input  8*CHANNELS  per-channel LUT index offset; channel c uses bits [8c+7:8c].
REQ-011 amplitude  input  8  common amplitude scale; 0 = flat midscale, 255 = near full swing.
REQ-012 pwm  output  CHANNELS  registered PWM outputs.
REQ-013 period_tick  output  1  one-cycle pulse on the cycle the PWM counter equals 0.
REQ-014 busy  output  1  high while the duty-computation sequencer is not IDLE.

Function
REQ-015 PWM counter cnt SHALL count 0..2^PWM_BITS-1 and wrap to 0, free-running regardless of en.
REQ-016 Phase accumulator SHALL add freq_word (mod 2^PHASE_BITS) on the cycle cnt wraps to 0.
REQ-017 freq_word, amplitude and phase_offset SHALL be sampled only when cnt==0; mid-period changes SHALL NOT affect the period in progress.
REQ-018 Sine LUT SHALL be 256 x 8 unsigned: lut[k] = floor(127.5 + 127.5*sin(2*pi*k/256) + 0.5); lut[0]=128, lut[64]=255, lut[192]=0.
REQ-019 Channel c LUT index SHALL be (phase_acc[PHASE_BITS-1 -: 8] + offset_c) mod 256.
REQ-020 Scaled sample SHALL be s = ((lut - 128) * amplitude) >>> 8 (signed, arithmetic shift, floor) + 128, result in 0..255.
REQ-021 Duty SHALL be s << (PWM_BITS-8) counts.
REQ-022 Sequencer FSM states: IDLE, LOOKUP, SCALE, STORE; IDLE->LOOKUP when cnt==0; LOOKUP->SCALE->STORE per channel; STORE->LOOKUP for next channel, STORE->IDLE after channel CHANNELS-1.
REQ-023 STORE SHALL write the channel's shadow duty register; sequencer SHALL finish in 3*CHANNELS+1 cycles after cnt==0.
REQ-024 Design SHALL require 2^PWM_BITS >= 4*CHANNELS+4 (elaboration-time check).
REQ-025 All shadow duties SHALL copy to active duties simultaneously on the cycle cnt wraps to 0; outputs therefore lag the sampled inputs by exactly one PWM period.
REQ-026 pwm[c] SHALL be registered: next value = (cnt < active_duty_c) when en=1, else IDLE_LEVEL; one-cycle latency from cnt.
REQ-027 Duty 0 SHALL give pwm low the entire period; no duty value SHALL give a runt or glitch pulse at period boundaries.
REQ-028 en deassertion SHALL force IDLE_LEVEL on the next cycle without disturbing cnt, phase_acc or the sequencer; reassertion SHALL resume mid-period using the current active duty.

Reset
REQ-029 While rst_n=0 at a clock edge: cnt=0, phase_acc=0, FSM=IDLE, shadow and active duties=0, pwm=IDLE_LEVEL, period_tick=0, busy=0.
REQ-030 Reset asserted mid-sequence SHALL abort the sequencer to IDLE with no partial shadow update surviving.
REQ-031 First cycle after reset release SHALL have cnt=0 and start a sequence (busy=1 next cycle); pwm follows duty 0 (low) for the first period when en=1.

Verification (CHANNELS=2, PWM_BITS=8, PHASE_BITS=24)
REQ-032 Reset 3 cycles, en=1, freq_word=0, amplitude=0 -> first period pwm=2'b00; every later period both channels high exactly 128 of 256 cycles.
REQ-033 freq_word=0, amplitude=255, offsets ch0=64, ch1=192 -> from second period, ch0 high 254 cycles/period, ch1 always low.
REQ-034 freq_word=0x010000, amplitude=255, offsets 0 -> LUT index advances 1 per period; duty sequence repeats after 256 periods; period_tick exactly once per 256 cycles.
REQ-035 en dropped at cnt=50, raised at cnt=200 (duty 128) -> pwm=2'b11 cycles 51..200, then follows cnt<128 (low) until wrap.
REQ-036 rst_n pulsed low while busy=1 -> busy=0, duties 0, pwm=IDLE_LEVEL next cycle; a clean sequence restarts after release.
